// File: rtl/fmac_sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fmac_sched_pkg                                                     |
// | Shared constants for the FP MAC scheduler: FSM encoding, FP width, |
// | default requester count and datapath latency.                      |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
package fmac_sched_pkg;

  localparam int c_fp_w         = 32;
  localparam int c_def_nreq     = 4;
  localparam int c_def_pipe_lat = 4;

  localparam logic [1:0] c_st_run   = 2'd0;
  localparam logic [1:0] c_st_drain = 2'd1;
  localparam logic [1:0] c_st_idle  = 2'd2;

endpackage : fmac_sched_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_arbiter                                                         |
// | Combinational round-robin arbiter; search begins at i_ptr.         |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_gnt_idx,
  output logic             o_gnt_vld
);

  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_idx;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_gnt_vld = 1'b0;
    w_sum     = '0;
    w_idx     = '0;
    for (int k = 0; k < N; k++) begin
      // ptr < N and k < N, so one conditional subtract gives the modulo
      w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
      if (w_sum >= (IDX_W+1)'(N)) begin
        w_sum = w_sum - (IDX_W+1)'(N);
      end
      w_idx = w_sum[IDX_W-1:0];
      if (!o_gnt_vld && i_req[w_idx]) begin
        o_gnt_vld    = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_gnt_idx    = w_idx;
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/fmac_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fmac_sched                                                         |
// | Schedules NREQ requesters onto one shared FP MAC pipeline with     |
// | per-bank RAW hazard blocking, response routing and flush/drain.    |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module fmac_sched
  import fmac_sched_pkg::*;
#(
  parameter  int NREQ     = c_def_nreq,
  parameter  int PIPE_LAT = c_def_pipe_lat,
  localparam int SEL_W    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*c_fp_w-1:0]   req_a,
  input  logic [NREQ*c_fp_w-1:0]   req_b,
  input  logic [NREQ-1:0]          req_clr,
  output logic [NREQ-1:0]          req_ready,
  output logic                     mac_issue,
  output logic [c_fp_w-1:0]        mac_a,
  output logic [c_fp_w-1:0]        mac_b,
  output logic [SEL_W-1:0]         mac_sel,
  output logic                     mac_clr,
  input  logic [c_fp_w-1:0]        mac_result,
  output logic [NREQ-1:0]          resp_valid,
  output logic [c_fp_w-1:0]        resp_data,
  input  logic                     flush,
  output logic                     flush_done
);

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [SEL_W-1:0]    r_ptr;
  logic [PIPE_LAT-1:0] r_pipe_vld;
  logic [SEL_W-1:0]    r_pipe_tag [PIPE_LAT];
  logic [NREQ-1:0]     r_busy;
  logic [NREQ-1:0]     r_resp_valid;
  logic [c_fp_w-1:0]   r_resp_data;

  logic                w_ret_vld;
  logic [SEL_W-1:0]    w_ret_tag;
  logic [NREQ-1:0]     w_ret_mask;
  logic                w_can_issue;
  logic [NREQ-1:0]     w_elig;
  logic [NREQ-1:0]     w_gnt;
  logic [SEL_W-1:0]    w_gnt_idx;
  logic                w_gnt_vld;

  assign w_ret_vld  = r_pipe_vld[PIPE_LAT-1];
  assign w_ret_tag  = r_pipe_tag[PIPE_LAT-1];
  assign w_ret_mask = w_ret_vld ? (NREQ'(1) << w_ret_tag) : '0;

  // A bank retiring this cycle is already free, so it may be regranted now
  assign w_can_issue = resetn && (r_state == c_st_run) && !flush;
  assign w_elig      = req_valid & ~(r_busy & ~w_ret_mask) & {NREQ{w_can_issue}};

  rr_arbiter #(
    .N     (NREQ),
    .IDX_W (SEL_W)
  ) u_arb (
    .i_req     (w_elig),
    .i_ptr     (r_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_gnt_vld (w_gnt_vld)
  );

  assign req_ready  = w_gnt;
  assign mac_issue  = w_gnt_vld;
  assign mac_sel    = w_gnt_idx;
  assign mac_a      = req_a[w_gnt_idx*c_fp_w +: c_fp_w];
  assign mac_b      = req_b[w_gnt_idx*c_fp_w +: c_fp_w];
  assign mac_clr    = req_clr[w_gnt_idx];
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign flush_done = (r_state == c_st_idle) && flush;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_run:   if (flush)             w_state_nxt = c_st_drain;
      c_st_drain: if (r_pipe_vld == '0)  w_state_nxt = c_st_idle;
      c_st_idle:  if (!flush)            w_state_nxt = c_st_run;
      default:                           w_state_nxt = c_st_run;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state      <= c_st_run;
      r_ptr        <= '0;
      r_pipe_vld   <= '0;
      r_busy       <= '0;
      r_resp_valid <= '0;
      r_resp_data  <= '0;
      for (int s = 0; s < PIPE_LAT; s++) begin
        r_pipe_tag[s] <= '0;
      end
    end else begin
      r_state    <= w_state_nxt;
      r_pipe_vld <= {r_pipe_vld[PIPE_LAT-2:0], w_gnt_vld};
      r_pipe_tag[0] <= w_gnt_idx;
      for (int s = 1; s < PIPE_LAT; s++) begin
        r_pipe_tag[s] <= r_pipe_tag[s-1];
      end
      r_busy       <= (r_busy & ~w_ret_mask) | w_gnt;
      r_resp_valid <= w_ret_mask;
      if (w_ret_vld) begin
        r_resp_data <= mac_result;
      end
      if (w_gnt_vld) begin
        r_ptr <= (w_gnt_idx == SEL_W'(NREQ-1)) ? '0 : w_gnt_idx + SEL_W'(1);
      end
    end
  end

endmodule : fmac_sched
`default_nettype wire
